// File: rtl/uart_host_link.sv
// Host-side UART link for the tracker: sends the init frame and
// receives the result frame, each 8 bytes of 8N1.
module uart_host_link #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        iclk,
  input  logic        s_rst_n,
  input  logic        cmd_start,
  input  logic [15:0] cmd_x,
  input  logic [15:0] cmd_y,
  input  logic [15:0] cmd_w,
  input  logic [15:0] cmd_h,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic        uart_tx_o,
  input  logic        uart_rx_i,
  output logic        res_valid,
  output logic [15:0] res_x,
  output logic [15:0] res_y,
  output logic [15:0] res_w,
  output logic [15:0] res_h,
  output logic        res_err
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int TMO  = TIMEOUT_BITS * CPB;
  localparam int CW   = $clog2(CPB + 1);
  localparam int TW   = $clog2(TMO + 1);

  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [TW-1:0] TMO_M1  = TW'(TMO - 1);

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_STOP, T_DONE
  } tx_st_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_WAIT
  } rx_st_t;

  tx_st_t        tx_st;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [2:0]    tx_byte;
  logic [7:0]    tx_sh;
  logic [63:0]   tx_frame;

  always_ff @(posedge iclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      tx_st     <= T_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_byte   <= '0;
      tx_sh     <= '0;
      tx_frame  <= '0;
      uart_tx_o <= 1'b1;
      cmd_busy  <= 1'b0;
      cmd_done  <= 1'b0;
    end else begin
      unique case (tx_st)
        // DONE behaves like IDLE so a start on the done cycle is taken
        T_IDLE, T_DONE: begin
          cmd_done <= 1'b0;
          tx_st    <= T_IDLE;
          if (cmd_start) begin
            tx_frame  <= {cmd_x, cmd_y, cmd_w, cmd_h};
            tx_sh     <= cmd_x[15:8];
            tx_cnt    <= '0;
            tx_byte   <= '0;
            uart_tx_o <= 1'b0;
            cmd_busy  <= 1'b1;
            tx_st     <= T_START;
          end
        end
        T_START: begin
          if (tx_cnt == CPB_M1) begin
            tx_cnt    <= '0;
            tx_bit    <= '0;
            uart_tx_o <= tx_sh[0];
            tx_st     <= T_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        T_DATA: begin
          if (tx_cnt == CPB_M1) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_tx_o <= 1'b1;
              tx_st     <= T_STOP;
            end else begin
              tx_bit    <= tx_bit + 3'd1;
              uart_tx_o <= tx_sh[1];
              tx_sh     <= {1'b0, tx_sh[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        T_STOP: begin
          if (tx_cnt == CPB_M1) begin
            tx_cnt <= '0;
            if (tx_byte == 3'd7) begin
              cmd_busy <= 1'b0;
              cmd_done <= 1'b1;
              tx_st    <= T_DONE;
            end else begin
              tx_byte   <= tx_byte + 3'd1;
              tx_sh     <= tx_frame[55:48];
              tx_frame  <= {tx_frame[55:0], 8'h00};
              uart_tx_o <= 1'b0;
              tx_st     <= T_START;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_st <= T_IDLE;
      endcase
    end
  end

  rx_st_t        rx_st;
  logic          rx_s1;
  logic          rx_s2;
  logic          rx_q;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_sh;
  logic [55:0]   rx_asm;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge iclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rx_st     <= R_IDLE;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_q      <= 1'b1;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_idx    <= '0;
      rx_sh     <= '0;
      rx_asm    <= '0;
      tmo_cnt   <= '0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_x     <= '0;
      res_y     <= '0;
      res_w     <= '0;
      res_h     <= '0;
    end else begin
      rx_s1     <= uart_rx_i;
      rx_s2     <= rx_s1;
      rx_q      <= rx_s2;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      unique case (rx_st)
        R_IDLE: begin
          if (rx_q && !rx_s2) begin
            rx_cnt <= '0;
            rx_st  <= R_START;
          end else if (rx_idx != 3'd0) begin
            if (tmo_cnt == TMO_M1) begin
              res_err <= 1'b1;
              rx_idx  <= '0;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
        end
        // a start bit that is high again at mid-bit was only a glitch
        R_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s2 ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        R_DATA: begin
          if (rx_cnt == CPB_M1) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_st <= R_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        R_STOP: begin
          if (rx_cnt == CPB_M1) begin
            rx_cnt  <= '0;
            tmo_cnt <= '0;
            rx_idx  <= '0;
            if (rx_s2) begin
              rx_st  <= R_IDLE;
              rx_asm <= {rx_asm[47:0], rx_sh};
              if (rx_idx == 3'd7) begin
                {res_x, res_y, res_w, res_h} <= {rx_asm, rx_sh};
                res_valid <= 1'b1;
              end else begin
                rx_idx <= rx_idx + 3'd1;
              end
            end else begin
              res_err <= 1'b1;
              rx_st   <= R_WAIT;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        R_WAIT: begin
          if (rx_s2) rx_st <= R_IDLE;
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

endmodule
